// File: rtl/stream_receiver_pkg.sv
// ---------------------------------------------------------------------------
// stream_receiver_pkg
// Shared definitions for the serial stream receiver:
//   BYTE_WIDTH        - width of one received byte
//   DEF_SYNC_STAGES   - default synchronizer depth on the serial inputs
//   DEF_TIMEOUT       - default intra-byte edge timeout in clk cycles
//   rx_state_t        - framing FSM state encoding
//   shift_msb_first() - shift-register helper (MSB arrives first)
// ---------------------------------------------------------------------------
package stream_receiver_pkg;

    localparam int BYTE_WIDTH      = 8;
    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_TIMEOUT     = 64;
    localparam int BIT_CNT_W       = $clog2(BYTE_WIDTH + 1);

    typedef enum logic [1:0] {
        ST_HUNT = 2'd0,
        ST_RECV = 2'd1,
        ST_GAP  = 2'd2
    } rx_state_t;

    // Append one bit at the LSB end; earlier bits move towards the MSB.
    function automatic logic [BYTE_WIDTH-1:0] shift_msb_first(
        input logic [BYTE_WIDTH-1:0] cur,
        input logic                  bit_in
    );
        return {cur[BYTE_WIDTH-2:0], bit_in};
    endfunction

endpackage

// File: rtl/bit_synchronizer.sv
// ---------------------------------------------------------------------------
// bit_synchronizer
// Multi-flop synchronizer bringing one asynchronous bit into the clk domain.
// Ports:
//   clk - destination clock
//   rst - asynchronous active-high reset, clears every stage to 0
//   d   - asynchronous input bit
//   q   - synchronized output (last stage)
// DEPTH must be at least 2.
// ---------------------------------------------------------------------------
module bit_synchronizer #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [DEPTH-1:0] stage_r;

    // Synchronizer shift chain; stage 0 is the metastability-exposed flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage_r <= {DEPTH{1'b0}};
        end else begin
            stage_r <= {stage_r[DEPTH-2:0], d};
        end
    end

    assign q = stage_r[DEPTH-1];

endmodule

// File: rtl/stream_receiver.sv
// ---------------------------------------------------------------------------
// stream_receiver
// Receives a framed serial byte stream (data clock, data, byte-start marker)
// that is asynchronous to clk, assembles MSB-first bytes and presents them
// through a valid/ready holding register.
// Ports:
//   clk       - system clock
//   rst       - asynchronous active-high reset
//   dataClkIn - serial data clock from the link (asynchronous)
//   dataIn    - serial data bit, valid at the dataClkIn rising edge
//   syncIn    - byte-start marker, high during bit 7 of each byte
//   rxByte    - received byte, valid while rxValid is high
//   rxValid   - holding register full
//   rxReady   - consumer accepts rxByte when rxValid and rxReady are high
//   locked    - a byte has been framed correctly since the last error/reset
//   frameErr  - one-cycle pulse per framing or timeout error
//   overrun   - sticky: a completed byte was dropped (cleared by reset only)
// ---------------------------------------------------------------------------
module stream_receiver
    import stream_receiver_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int TIMEOUT     = DEF_TIMEOUT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  dataClkIn,
    input  logic                  dataIn,
    input  logic                  syncIn,
    output logic [BYTE_WIDTH-1:0] rxByte,
    output logic                  rxValid,
    input  logic                  rxReady,
    output logic                  locked,
    output logic                  frameErr,
    output logic                  overrun
);

    localparam int TMO_W = $clog2(TIMEOUT + 1);
    localparam logic [BIT_CNT_W-1:0] CNT_ZERO = {BIT_CNT_W{1'b0}};
    localparam logic [BIT_CNT_W-1:0] CNT_ONE  = BIT_CNT_W'(1);
    localparam logic [BIT_CNT_W-1:0] CNT_FULL = BIT_CNT_W'(BYTE_WIDTH);
    localparam logic [TMO_W-1:0]     TMO_ZERO = {TMO_W{1'b0}};
    localparam logic [TMO_W-1:0]     TMO_ONE  = TMO_W'(1);
    localparam logic [TMO_W-1:0]     TMO_LAST = TMO_W'(TIMEOUT - 1);
    localparam logic [BYTE_WIDTH-1:0] BYTE_ZERO = {BYTE_WIDTH{1'b0}};

    // Synchronized serial inputs
    logic clk_sync_s;
    logic data_sync_s;
    logic mark_sync_s;

    // Edge detection
    logic [SYNC_STAGES-1:0] warm_r;
    logic                   warm_s;
    logic                   clk_prev_r;
    logic                   edge_r;

    // Framing FSM and datapath
    rx_state_t              state_r;
    rx_state_t              state_n;
    logic [BYTE_WIDTH-1:0]  shift_r;
    logic [BYTE_WIDTH-1:0]  shift_n;
    logic [BIT_CNT_W-1:0]   cnt_r;
    logic [BIT_CNT_W-1:0]   cnt_n;
    logic [TMO_W-1:0]       tmo_r;
    logic [TMO_W-1:0]       tmo_n;
    logic [BYTE_WIDTH-1:0]  shifted_s;
    logic                   done_s;
    logic                   err_s;

    // Output registers
    logic [BYTE_WIDTH-1:0]  rx_byte_r;
    logic                   rx_valid_r;
    logic                   locked_r;
    logic                   frame_err_r;
    logic                   overrun_r;

    bit_synchronizer #(.DEPTH(SYNC_STAGES)) u_sync_clk (
        .clk (clk),
        .rst (rst),
        .d   (dataClkIn),
        .q   (clk_sync_s)
    );

    bit_synchronizer #(.DEPTH(SYNC_STAGES)) u_sync_data (
        .clk (clk),
        .rst (rst),
        .d   (dataIn),
        .q   (data_sync_s)
    );

    bit_synchronizer #(.DEPTH(SYNC_STAGES)) u_sync_mark (
        .clk (clk),
        .rst (rst),
        .d   (syncIn),
        .q   (mark_sync_s)
    );

    // warm_s rises once the synchronizer chain holds real samples taken after
    // reset release. Until then the previous-level register is forced high, so
    // a link clock already high at release is treated as "no new edge".
    assign warm_s = warm_r[SYNC_STAGES-1];

    // Warm-up tracker and registered rising-edge strobe on the data clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            warm_r     <= {SYNC_STAGES{1'b0}};
            clk_prev_r <= 1'b1;
            edge_r     <= 1'b0;
        end else begin
            warm_r     <= {warm_r[SYNC_STAGES-2:0], 1'b1};
            clk_prev_r <= warm_s ? clk_sync_s : 1'b1;
            edge_r     <= warm_s & clk_sync_s & ~clk_prev_r;
        end
    end

    assign shifted_s = shift_msb_first(shift_r, data_sync_s);

    // Framing FSM: next state, shift/count/timeout updates, done/error events.
    // tmo_r counts clk cycles since the last edge strobe while in RECV.
    always_comb begin
        state_n = state_r;
        shift_n = shift_r;
        cnt_n   = cnt_r;
        tmo_n   = TMO_ZERO;
        done_s  = 1'b0;
        err_s   = 1'b0;
        case (state_r)
            ST_HUNT: begin
                if (edge_r && mark_sync_s) begin
                    shift_n = {{(BYTE_WIDTH-1){1'b0}}, data_sync_s};
                    cnt_n   = CNT_ONE;
                    tmo_n   = TMO_ONE;
                    state_n = ST_RECV;
                end else begin
                    state_n = ST_HUNT;
                end
            end
            ST_RECV: begin
                if (edge_r) begin
                    tmo_n = TMO_ONE;
                    if (mark_sync_s) begin
                        // Marker arrived early: this bit starts a fresh byte.
                        err_s   = 1'b1;
                        shift_n = {{(BYTE_WIDTH-1){1'b0}}, data_sync_s};
                        cnt_n   = CNT_ONE;
                    end else if ((cnt_r + CNT_ONE) == CNT_FULL) begin
                        done_s  = 1'b1;
                        shift_n = shifted_s;
                        cnt_n   = CNT_ZERO;
                        state_n = ST_GAP;
                    end else begin
                        shift_n = shifted_s;
                        cnt_n   = cnt_r + CNT_ONE;
                    end
                end else if (tmo_r == TMO_LAST) begin
                    err_s   = 1'b1;
                    shift_n = BYTE_ZERO;
                    cnt_n   = CNT_ZERO;
                    state_n = ST_HUNT;
                end else begin
                    tmo_n = tmo_r + TMO_ONE;
                end
            end
            ST_GAP: begin
                if (edge_r && mark_sync_s) begin
                    shift_n = {{(BYTE_WIDTH-1){1'b0}}, data_sync_s};
                    cnt_n   = CNT_ONE;
                    tmo_n   = TMO_ONE;
                    state_n = ST_RECV;
                end else if (edge_r) begin
                    err_s   = 1'b1;
                    state_n = ST_HUNT;
                end else begin
                    state_n = ST_GAP;
                end
            end
            default: begin
                shift_n = BYTE_ZERO;
                cnt_n   = CNT_ZERO;
                state_n = ST_HUNT;
            end
        endcase
    end

    // FSM state, shift register, bit counter and timeout counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_HUNT;
            shift_r <= BYTE_ZERO;
            cnt_r   <= CNT_ZERO;
            tmo_r   <= TMO_ZERO;
        end else begin
            state_r <= state_n;
            shift_r <= shift_n;
            cnt_r   <= cnt_n;
            tmo_r   <= tmo_n;
        end
    end

    // Holding register, handshake, lock/error/overrun status.
    // A completion coinciding with an accept reloads and keeps rxValid high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_byte_r   <= BYTE_ZERO;
            rx_valid_r  <= 1'b0;
            locked_r    <= 1'b0;
            frame_err_r <= 1'b0;
            overrun_r   <= 1'b0;
        end else begin
            frame_err_r <= err_s;
            if (err_s) begin
                locked_r <= 1'b0;
            end else if (done_s) begin
                locked_r <= 1'b1;
            end
            if (done_s && (!rx_valid_r || rxReady)) begin
                rx_byte_r  <= shifted_s;
                rx_valid_r <= 1'b1;
            end else if (done_s) begin
                overrun_r <= 1'b1;
            end else if (rx_valid_r && rxReady) begin
                rx_valid_r <= 1'b0;
            end
        end
    end

    assign rxByte   = rx_byte_r;
    assign rxValid  = rx_valid_r;
    assign locked   = locked_r;
    assign frameErr = frame_err_r;
    assign overrun  = overrun_r;

endmodule

// File: doc/stream_receiver.md
STREAM_RECEIVER -- requirements
Module: stream_receiver

Interface
REQ-001 Parameter SYNC_STAGES, default 2: synchronizer depth on every serial input, minimum 2.
REQ-002 Parameter TIMEOUT, default 64: maximum clk cycles allowed between consecutive dataClkIn rising edges inside one byte.
REQ-003 clk  in  1  system clock; the only clock in the block.
REQ-004 rst  in  1  reset; asynchronous, active-high.
REQ-005 dataClkIn  in  1  serial data clock from the link, single-ended, asynchronous to clk.
REQ-006 dataIn  in  1  serial data bit, MSB first, valid at the dataClkIn rising edge.
REQ-007 syncIn  in  1  byte-start marker, high during the first bit (bit 7) of each byte.
REQ-008 rxByte  out  8  received byte, valid while rxValid is high.
REQ-009 rxValid  out  1  output holding register full.
REQ-010 rxReady  in  1  consumer accepts rxByte when rxValid and rxReady are both high.
REQ-011 locked  out  1  at least one byte has been framed correctly since the last error or reset.
REQ-012 frameErr  out  1  single-cycle pulse on each framing or timeout error.
REQ-013 overrun  out  1  sticky flag: a completed byte was dropped.

Function
REQ-014 Input timing: dataClkIn, dataIn and syncIn shall each pass through SYNC_STAGES flip-flops of identical depth; a registered rising-edge detect on synchronized dataClkIn shall produce an internal one-cycle edge strobe.
REQ-015 Link timing: the link shall hold dataClkIn high and low for at least SYNC_STAGES+2 clk cycles each, and dataIn/syncIn shall be stable for that window around each rising edge.
REQ-016 Sampling: synchronized dataIn and syncIn shall be sampled only in the edge-strobe cycle.
REQ-017 FSM states: HUNT, RECV and GAP.
REQ-018 HUNT transitions:
- edge with sync=1: load bit into the shift register, set bit count to 1, go to RECV.
- edge with sync=0: ignore the bit.
REQ-019 RECV transitions:
- edge with sync=0: shift the bit in (MSB first) and increment the bit count.
- when the count reaches 8: byte complete, go to GAP.
REQ-020 RECV edge with sync=1 before the count reaches 8: pulse frameErr, clear locked, restart the byte with this bit (count=1), stay in RECV.
REQ-021 RECV timeout: if TIMEOUT clk cycles elapse without an edge, pulse frameErr, clear locked and go to HUNT. The timeout counter resets on every edge and runs only in RECV.
REQ-022 GAP transitions (no timeout, idle unlimited):
- edge with sync=1: start a new byte and go to RECV.
- edge with sync=0: pulse frameErr, clear locked, go to HUNT.
REQ-023 Byte completion: set locked, and load rxByte and assert rxValid in the cycle after the 8th edge strobe. Total latency from the 8th dataClkIn rising edge at the pin to rxValid is SYNC_STAGES+2 clk cycles.
REQ-024 Handshake: rxValid shall stay high and rxByte stable until a cycle with rxReady=1, after which rxValid drops, unless a new byte loads in that same cycle.
REQ-025 Completion while rxValid=1 and rxReady=0: drop the new byte, set overrun, keep the held rxByte unchanged.
REQ-026 Completion in the same cycle as an accept (rxValid=1, rxReady=1): load the new byte, keep rxValid=1, no overrun.
REQ-027 overrun shall clear only on reset.

Reset
REQ-028 Asserting rst at any time shall immediately set:
- state HUNT, shift register 0, bit count 0, timeout counter 0, all synchronizers 0;
- rxByte=8'h00, rxValid=0, locked=0, frameErr=0, overrun=0.
REQ-029 After rst deasserts, a dataClkIn level that is already high shall not produce an edge strobe.
REQ-030 A partially received byte shall be discarded on reset.

Structure
REQ-031 Shared package shall hold: BYTE_WIDTH=8, the FSM state encoding, and default SYNC_STAGES and TIMEOUT.
REQ-032 One sub-module, bit_synchronizer (parameterized depth, asynchronous reset), shall be instantiated three times.
REQ-033 All other logic (edge detect, FSM, counters, holding register) shall live in stream_receiver.

Verification
REQ-034 Bytes 8'hA5 then 8'h3C sent with sync on each bit 7, rxReady=1 -> rxValid pulses twice with A5 then 3C, each exactly SYNC_STAGES+2 cycles after the 8th edge; locked=1; no frameErr.
REQ-035 Bits before the first sync, then 8'h81 -> leading bits ignored, single rxByte=81.
REQ-036 Sync reasserted at bit 4 of a byte, then a full 8'h5A -> one frameErr pulse, then rxByte=5A; locked cleared at the error and set again on the 5A completion.
REQ-037 Three bits of a byte, then dataClkIn stalled for 64 cycles -> frameErr exactly at cycle 64 after the last edge, FSM back in HUNT, no byte output.
REQ-038 rxReady=0 held while 8'h11 and 8'h22 arrive -> rxByte stays 11, overrun=1; then rxReady=1 accepts 11 and rxValid drops.
REQ-039 rst asserted mid-byte, released, then 8'hC3 sent -> all outputs zero during reset, only C3 received afterwards.
